// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one sram-like memory port between the IF-stage instruction
//   requester and the MEM-stage data requester. Address phases are
//   arbitrated and the grant is locked until the address is accepted.
//   The owner of every accepted request is recorded in an in-order ID FIFO.
//   Each response (data_ok/rdata) is routed to the requester at the FIFO head.
//
// Ports
//   clk, resetn           clock, synchronous active-low reset
//   inst_* / data_*       requester address phase in, addr_ok/data_ok/rdata out
//   mem_*                 shared port request out, addr_ok/data_ok/rdata in
//   pending_cnt           accepted-but-not-returned request count
//   arb_err               sticky protocol error (orphan response or dropped locked req)

module sram_port_arbiter #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned DATA_PRIO   = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,

    output logic [3:0]  pending_cnt,
    output logic        arb_err
);

    localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [PtrW-1:0] PtrLast = PtrW'(OUTSTANDING - 1);

    // ID encoding: 0 = inst, 1 = data
    logic                   lock_vld_q, lock_vld_d;
    logic                   lock_id_q,  lock_id_d;
    logic [OUTSTANDING-1:0] id_q,       id_d;
    logic [PtrW-1:0]        wr_ptr_q,   wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q,   rd_ptr_d;
    logic [3:0]             cnt_q,      cnt_d;
    logic                   arb_err_q,  arb_err_d;

    logic grant;
    logic gnt_req;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_id;

    // Grant selection: lock overrides priority
    always_comb begin
        grant = 1'b0;
        if (lock_vld_q) begin
            grant = lock_id_q;
        end else if (DATA_PRIO != 0) begin
            grant = data_req;
        end else begin
            grant = ~inst_req & data_req;
        end
    end

    assign gnt_req = grant ? data_req : inst_req;
    assign full    = (cnt_q == 4'(OUTSTANDING));
    assign empty   = (cnt_q == 4'd0);
    assign mem_req = gnt_req & ~full;
    assign push    = mem_req & mem_addr_ok;
    // Only entries pushed in earlier cycles are visible at the head
    assign pop     = mem_data_ok & ~empty;
    assign head_id = id_q[rd_ptr_q];

    always_comb begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
        if (grant) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    assign inst_addr_ok = push & ~grant;
    assign data_addr_ok = push & grant;
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop & head_id;
    assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;
    assign pending_cnt  = cnt_q;
    assign arb_err      = arb_err_q;

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        id_d       = id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        arb_err_d  = arb_err_q;

        // Lock while the granted requester waits, including a full-FIFO stall,
        // so it keeps the grant once space frees up.
        if (push || !gnt_req) begin
            lock_vld_d = 1'b0;
        end else begin
            lock_vld_d = 1'b1;
            lock_id_d  = grant;
        end

        if (push) begin
            id_d[wr_ptr_q] = grant;
            wr_ptr_d       = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 4'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (mem_data_ok && empty) begin
            arb_err_d = 1'b1;
        end
        if (lock_vld_q && !gnt_req) begin
            arb_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            id_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= 4'd0;
            arb_err_q  <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            id_q       <= id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            arb_err_q  <= arb_err_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  pending_cnt;
    logic        arb_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .OUTSTANDING(2),
        .DATA_PRIO  (1)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_wr     (inst_wr),
        .inst_size   (inst_size),
        .inst_wstrb  (inst_wstrb),
        .inst_addr   (inst_addr),
        .inst_wdata  (inst_wdata),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .pending_cnt (pending_cnt),
        .arb_err     (arb_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply stimulus for the current cycle and let combinational paths settle.
    task automatic drive(input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic [31:0] daddr,
                         input logic aok, input logic dok, input logic [31:0] rdata);
        inst_req    = ireq;
        inst_addr   = iaddr;
        data_req    = dreq;
        data_addr   = daddr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rdata;
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_wdata = 32'h0;
        data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'h3; data_wdata = 32'hdead_beef;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();

        // Reset, no requests
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_pending", {28'd0, pending_cnt}, 32'd0);
        check("rst_arb_err", {31'd0, arb_err}, 32'd0);
        resetn = 1'b1;
        tick();

        // Single inst fetch, addr_ok one cycle late
        drive(1, 32'h1C00_0000, 0, 0, 0, 0, 0);
        check("i1_mem_req", {31'd0, mem_req}, 32'd1);
        check("i1_mem_addr", mem_addr, 32'h1C00_0000);
        check("i1_addr_ok_early", {31'd0, inst_addr_ok}, 32'd0);
        tick();
        drive(1, 32'h1C00_0000, 0, 0, 1, 0, 0);
        check("i1_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        check("i1_d_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("i1_pending", {28'd0, pending_cnt}, 32'd1);
        drive(0, 0, 0, 0, 0, 1, 32'h0280_0C05);
        check("i1_data_ok", {31'd0, inst_data_ok}, 32'd1);
        check("i1_rdata", inst_rdata, 32'h0280_0C05);
        check("i1_d_data_ok", {31'd0, data_data_ok}, 32'd0);
        check("i1_d_rdata", data_rdata, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("i1_pending_end", {28'd0, pending_cnt}, 32'd0);

        // Simultaneous fresh requests: data wins, inst follows
        drive(1, 32'h0000_0100, 1, 32'h0000_0200, 1, 0, 0);
        check("p_d_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("p_i_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        check("p_mem_addr_d", mem_addr, 32'h0000_0200);
        check("p_mem_wr_d", {31'd0, mem_wr}, 32'd1);
        check("p_mem_wstrb_d", {28'd0, mem_wstrb}, 32'h3);
        tick();
        drive(1, 32'h0000_0100, 0, 0, 1, 0, 0);
        check("p_i_addr_ok2", {31'd0, inst_addr_ok}, 32'd1);
        check("p_mem_addr_i", mem_addr, 32'h0000_0100);
        check("p_mem_wr_i", {31'd0, mem_wr}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h0000_AAAA);
        check("p_pending2", {28'd0, pending_cnt}, 32'd2);
        check("p_rsp1_d", {31'd0, data_data_ok}, 32'd1);
        check("p_rsp1_rdata", data_rdata, 32'h0000_AAAA);
        check("p_rsp1_i", {31'd0, inst_data_ok}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h0000_BBBB);
        check("p_rsp2_i", {31'd0, inst_data_ok}, 32'd1);
        check("p_rsp2_rdata", inst_rdata, 32'h0000_BBBB);
        check("p_rsp2_d", {31'd0, data_data_ok}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("p_pending0", {28'd0, pending_cnt}, 32'd0);

        // Lock: inst stalls 3 cycles, data arrives meanwhile
        drive(1, 32'h0000_1000, 0, 0, 0, 0, 0);
        check("l_c1_addr", mem_addr, 32'h0000_1000);
        tick();
        for (int c = 2; c <= 3; c++) begin
            drive(1, 32'h0000_1000, 1, 32'h0000_2000, 0, 0, 0);
            check($sformatf("l_c%0d_addr", c), mem_addr, 32'h0000_1000);
            check($sformatf("l_c%0d_d_ok", c), {31'd0, data_addr_ok}, 32'd0);
            tick();
        end
        drive(1, 32'h0000_1000, 1, 32'h0000_2000, 1, 0, 0);
        check("l_c4_i_ok", {31'd0, inst_addr_ok}, 32'd1);
        check("l_c4_d_ok", {31'd0, data_addr_ok}, 32'd0);
        tick();
        drive(0, 0, 1, 32'h0000_2000, 1, 0, 0);
        check("l_c5_d_ok", {31'd0, data_addr_ok}, 32'd1);
        check("l_c5_addr", mem_addr, 32'h0000_2000);
        tick();

        // Full: third request stalls
        drive(0, 0, 1, 32'h0000_3000, 1, 0, 0);
        check("f_pending", {28'd0, pending_cnt}, 32'd2);
        check("f_mem_req", {31'd0, mem_req}, 32'd0);
        check("f_d_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        tick();
        // Response while full: pop only, still no push this cycle
        drive(0, 0, 1, 32'h0000_3000, 1, 1, 32'h0000_0011);
        check("f_pop_mem_req", {31'd0, mem_req}, 32'd0);
        check("f_pop_i_ok", {31'd0, inst_data_ok}, 32'd1);
        check("f_pop_rdata", inst_rdata, 32'h0000_0011);
        tick();
        // Push and pop together, count unchanged
        drive(0, 0, 1, 32'h0000_3000, 1, 1, 32'h0000_0022);
        check("w1_d_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        check("w1_d_data_ok", {31'd0, data_data_ok}, 32'd1);
        check("w1_d_rdata", data_rdata, 32'h0000_0022);
        tick();
        drive(1, 32'h0000_4000, 0, 0, 1, 1, 32'h0000_0033);
        check("w1_pending", {28'd0, pending_cnt}, 32'd1);
        check("w2_i_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        check("w2_d_data_ok", {31'd0, data_data_ok}, 32'd1);
        check("w2_i_data_ok", {31'd0, inst_data_ok}, 32'd0);
        check("w2_d_rdata", data_rdata, 32'h0000_0033);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0044);
        check("w2_pending", {28'd0, pending_cnt}, 32'd1);
        check("w3_i_data_ok", {31'd0, inst_data_ok}, 32'd1);
        check("w3_i_rdata", inst_rdata, 32'h0000_0044);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("w3_pending", {28'd0, pending_cnt}, 32'd0);
        check("w3_arb_err", {31'd0, arb_err}, 32'd0);

        // Requester drops a locked request
        drive(1, 32'h0000_5000, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("drop_mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        drive(0, 0, 1, 32'h0000_6000, 0, 0, 0);
        check("drop_arb_err", {31'd0, arb_err}, 32'd1);
        check("drop_unlock_addr", mem_addr, 32'h0000_6000);
        check("drop_unlock_req", {31'd0, mem_req}, 32'd1);
        tick();

        // Orphan response on an empty FIFO
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        resetn = 1'b1;
        check("orph_pre_err", {31'd0, arb_err}, 32'd0);
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0055);
        check("orph_i_ok", {31'd0, inst_data_ok}, 32'd0);
        check("orph_d_ok", {31'd0, data_data_ok}, 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        check("orph_err", {31'd0, arb_err}, 32'd1);
        check("orph_pending", {28'd0, pending_cnt}, 32'd0);
        tick(); tick();
        check("orph_sticky", {31'd0, arb_err}, 32'd1);
        resetn = 1'b0;
        tick();
        check("orph_cleared", {31'd0, arb_err}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
